// File: rtl/costas_probe_capture.sv
// Triggered multi-channel sample capture with valid/ready readout for the Costas-loop demodulator.
// Optional macro PROBE_DECIM_EN enables strobe decimation via the decim port.
module costas_probe_capture #(
  parameter int DW    = 15,
  parameter int CH    = 2,
  parameter int DEPTH = 128
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sample_ce,
  input  logic [CH*DW-1:0]                   sample_in,
  input  logic                               arm,
  input  logic                               abort,
  input  logic [1:0]                         trig_mode,
  input  logic                               trig_in,
  input  logic [DW-2:0]                      thr,
  input  logic [7:0]                         decim,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(DEPTH):0]             wr_cnt,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [DW-1:0]                      rd_data,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] rd_ch,
  output logic                               rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [AW:0]   LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_S   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_C   = CW'(CH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_READ} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_s_q, rd_s_d;
  logic [CW-1:0]   rd_c_q, rd_c_d;
  logic            fetch_done_q, fetch_done_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [CW-1:0]   rd_ch_q, rd_ch_d;
  logic            rd_last_q, rd_last_d;
  logic            done_q, done_d;
  logic            qual;
  logic            trig;
  logic            we;

  logic [DW-1:0]   mem [CH][DEPTH];

  // Qualified strobe generation.
`ifdef PROBE_DECIM_EN
  logic [7:0] dec_cnt_q, dec_cnt_d;

  assign qual = sample_ce && (dec_cnt_q == decim);

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (abort || (state_q == ST_IDLE && arm)) begin
      dec_cnt_d = '0;
    end else if (sample_ce) begin
      dec_cnt_d = (dec_cnt_q == decim) ? '0 : dec_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_cnt_q <= '0;
    else        dec_cnt_q <= dec_cnt_d;
  end
`else
  logic unused_decim;
  assign unused_decim = ^decim;
  assign qual         = sample_ce;
`endif

  // Channel-0 magnitude; the most negative code saturates to the largest positive.
  logic [DW-1:0] ch0, ch0_neg;
  logic [DW-2:0] ch0_mag;

  assign ch0     = sample_in[DW-1:0];
  assign ch0_neg = ~ch0 + 1'b1;
  assign ch0_mag = ch0[DW-1] ? (ch0_neg[DW-1] ? {(DW-1){1'b1}} : ch0_neg[DW-2:0])
                             : ch0[DW-2:0];

  always_comb begin
    case (trig_mode)
      2'd1:    trig = trig_in;
      2'd2:    trig = (ch0_mag >= thr);
      default: trig = 1'b1;
    endcase
  end

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_s_d       = rd_s_q;
    rd_c_d       = rd_c_q;
    fetch_done_d = fetch_done_q;
    rd_valid_d   = rd_valid_q;
    rd_data_d    = rd_data_q;
    rd_ch_d      = rd_ch_q;
    rd_last_d    = rd_last_q;
    done_d       = 1'b0;
    we           = 1'b0;

    if (abort) begin
      state_d    = ST_IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d  = ST_ARMED;
            wr_cnt_d = '0;
          end
        end
        ST_ARMED: begin
          if (qual && trig) begin
            we       = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
            state_d  = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (qual) begin
            we       = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
              state_d      = ST_READ;
              rd_s_d       = '0;
              rd_c_d       = '0;
              fetch_done_d = 1'b0;
            end
          end
        end
        ST_READ: begin
          if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
            if (rd_last_q) begin
              done_d    = 1'b1;
              rd_last_d = 1'b0;
              state_d   = ST_IDLE;
            end
          end
          // The output register refills whenever it is empty or being drained this cycle.
          if (!fetch_done_q && (!rd_valid_q || rd_ready)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[rd_c_q][rd_s_q];
            rd_ch_d    = rd_c_q;
            rd_last_d  = (rd_s_q == LAST_S) && (rd_c_q == LAST_C);
            if (rd_c_q == LAST_C) begin
              rd_c_d = '0;
              rd_s_d = rd_s_q + 1'b1;
              if (rd_s_q == LAST_S) fetch_done_d = 1'b1;
            end else begin
              rd_c_d = rd_c_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sample storage has no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < CH; k++) begin
        mem[k][wr_cnt_q[AW-1:0]] <= sample_in[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= '0;
      rd_s_q       <= '0;
      rd_c_q       <= '0;
      fetch_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_ch_q      <= '0;
      rd_last_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_s_q       <= rd_s_d;
      rd_c_q       <= rd_c_d;
      fetch_done_q <= fetch_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_ch_q      <= rd_ch_d;
      rd_last_q    <= rd_last_d;
      done_q       <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign wr_cnt   = wr_cnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_ch    = rd_ch_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_costas_probe_capture.sv
// Scoreboard bench for costas_probe_capture: directed captures push expected words,
// a negedge monitor pops and compares every transfer, done pulse and stall.
module tb_costas_probe_capture;

  localparam int DW    = 15;
  localparam int CH    = 2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ch;
    logic          last;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_ce = 1'b0;
  logic [CH*DW-1:0] sample_in = '0;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       trig_mode = 2'd0;
  logic             trig_in = 1'b0;
  logic [DW-2:0]    thr = '0;
  logic [7:0]       decim = 8'd0;
  logic             busy;
  logic             done;
  logic [3:0]       wr_cnt;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [DW-1:0]    rd_data;
  logic [0:0]       rd_ch;
  logic             rd_last;

  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  word_t exp_q[$];

  logic       bp_en = 1'b0;
  logic       rdy_level = 1'b1;
  logic [3:0] bp_pat = 4'b1001;
  logic [1:0] bp_idx = 2'd0;

  costas_probe_capture #(.DW(DW), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample_ce(sample_ce), .sample_in(sample_in),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_in(trig_in),
    .thr(thr), .decim(decim), .busy(busy), .done(done), .wr_cnt(wr_cnt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_ch(rd_ch), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_sample(input int c0, input int c1, input bit last);
    word_t w;
    w.data = DW'(c0); w.ch = 1'b0; w.last = 1'b0;
    exp_q.push_back(w);
    w.data = DW'(c1); w.ch = 1'b1; w.last = last;
    exp_q.push_back(w);
  endfunction

  task automatic strobe(input int c0, input int c1, input logic tin, input int gap);
    sample_in = {DW'(c1), DW'(c0)};
    sample_ce = 1'b1;
    trig_in   = tin;
    tick();
    sample_ce = 1'b0;
    trig_in   = 1'b0;
    for (int i = 1; i < gap; i++) tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("busy_after_arm", busy, 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, busy, 0);
    tick();
  endtask

  // Ready driver: fixed level or the repeating 1,0,0,1 backpressure pattern.
  always @(posedge clk) begin
    #1;
    rd_ready = bp_en ? bp_pat[bp_idx] : rdy_level;
    bp_idx   = bp_idx + 2'd1;
  end

  // Monitor / scoreboard.
  logic          stall_prev = 1'b0;
  logic          exp_done = 1'b0;
  logic [DW-1:0] snap_data;
  logic          snap_ch, snap_last;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (done || exp_done) check("done_pulse", done, exp_done);
      exp_done = 1'b0;
      if (stall_prev) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", rd_data, snap_data);
        check("stall_ch", rd_ch, snap_ch);
        check("stall_last", rd_last, snap_last);
      end
      stall_prev = rd_valid && !rd_ready && !abort;
      snap_data  = rd_data;
      snap_ch    = rd_ch;
      snap_last  = rd_last;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", rd_data, 32'hFFFF_FFFF);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("rd_data", rd_data, w.data);
          check("rd_ch", rd_ch, w.ch);
          check("rd_last", rd_last, w.last);
          if (w.last) exp_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;

    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_ch", rd_ch, 0);
    check("rst_rd_last", rd_last, 0);
    rst_n = 1'b1;
    tick();

    // Immediate capture, strobe every 4th cycle, ch0 = n, ch1 = -n.
    d0 = done_cnt;
    trig_mode = 2'd0;
    do_arm();
    check("arm_wr_cnt", wr_cnt, 0);
    for (int k = 0; k < 7; k++) begin
      push_sample(k, -k, 1'b0);
      strobe(k, -k, 1'b0, 4);
    end
    push_sample(7, -7, 1'b1);
    strobe(7, -7, 1'b0, 1);
    check("imm_wr_cnt", wr_cnt, 8);
    check("imm_valid_t1", rd_valid, 0);
    tick();
    check("imm_valid_t2", rd_valid, 1);
    wait_idle("imm_idle", 100);
    check("imm_done_cnt", done_cnt - d0, 1);
    check("imm_wr_cnt_hold", wr_cnt, 8);
    check("imm_queue", exp_q.size(), 0);

    // Threshold trigger: ramp crosses 100; then the most negative code triggers.
    d0 = done_cnt;
    trig_mode = 2'd2;
    thr = 14'd100;
    do_arm();
    strobe(90, 7, 1'b0, 2);
    strobe(95, 7, 1'b0, 2);
    check("thr_not_trig", wr_cnt, 0);
    for (int k = 0; k < 8; k++) begin
      push_sample(100 + 5*k, 7, k == 7);
      strobe(100 + 5*k, 7, 1'b0, 2);
    end
    wait_idle("thr_idle", 100);
    do_arm();
    strobe(99, 0, 1'b0, 2);
    check("thr_99_not_trig", wr_cnt, 0);
    push_sample(-16384, 0, 1'b0);
    strobe(-16384, 0, 1'b0, 2);
    check("thr_min_trig", wr_cnt, 1);
    for (int k = 1; k < 8; k++) begin
      push_sample(k, 0, k == 7);
      strobe(k, 0, 1'b0, 2);
    end
    wait_idle("thr_min_idle", 100);
    check("thr_done_cnt", done_cnt - d0, 2);
    check("thr_queue", exp_q.size(), 0);

    // Backpressure with ready pattern 1,0,0,1.
    d0 = done_cnt;
    trig_mode = 2'd0;
    bp_en = 1'b1;
    do_arm();
    for (int k = 0; k < 8; k++) begin
      push_sample(10*k + 1, 1000 + k, k == 7);
      strobe(10*k + 1, 1000 + k, 1'b0, 1);
    end
    wait_idle("bp_idle", 200);
    bp_en = 1'b0;
    check("bp_done_cnt", done_cnt - d0, 1);
    check("bp_queue", exp_q.size(), 0);

    // Abort mid-capture, arm+abort together, abort mid-read, then a clean capture.
    d0 = done_cnt;
    do_arm();
    for (int k = 0; k < 3; k++) strobe(k, k, 1'b0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_cap_busy", busy, 0);
    check("abort_cap_valid", rd_valid, 0);
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check("arm_abort_busy", busy, 0);
    rdy_level = 1'b0;
    do_arm();
    for (int k = 0; k < 8; k++) begin
      push_sample(20 + k, k, k == 7);
      strobe(20 + k, k, 1'b0, 1);
    end
    n = 0;
    while (!rd_valid && n < 50) begin
      tick();
      n++;
    end
    check("abort_rd_wait", rd_valid, 1);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rd_valid", rd_valid, 0);
    check("abort_rd_busy", busy, 0);
    exp_q.delete();
    tick(); tick();
    check("abort_no_done", done_cnt - d0, 0);
    rdy_level = 1'b1;
    tick();
    do_arm();
    for (int k = 0; k < 8; k++) begin
      push_sample(30 + k, 40 + k, k == 7);
      strobe(30 + k, 40 + k, 1'b0, 1);
    end
    wait_idle("rearm_idle", 100);
    check("rearm_done_cnt", done_cnt - d0, 1);
    check("rearm_queue", exp_q.size(), 0);

    // External trigger: only a trig_in coincident with a strobe starts capture; arm in CAPTURE ignored.
    d0 = done_cnt;
    trig_mode = 2'd1;
    do_arm();
    strobe(11, 111, 1'b0, 2);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    tick();
    strobe(12, 112, 1'b0, 2);
    check("ext_not_trig", wr_cnt, 0);
    push_sample(13, 113, 1'b0);
    strobe(13, 113, 1'b1, 2);
    check("ext_trig", wr_cnt, 1);
    for (int v = 14; v < 16; v++) begin
      push_sample(v, 100 + v, 1'b0);
      strobe(v, 100 + v, 1'b0, 2);
    end
    do_arm();
    check("ext_arm_ignored", wr_cnt, 3);
    for (int v = 16; v < 21; v++) begin
      push_sample(v, 100 + v, v == 20);
      strobe(v, 100 + v, 1'b0, 2);
    end
    wait_idle("ext_idle", 100);
    check("ext_done_cnt", done_cnt - d0, 1);
    check("ext_queue", exp_q.size(), 0);

    // Decimation 2: every 3rd strobe when enabled, every strobe otherwise; extra strobes hit READ.
    d0 = done_cnt;
    trig_mode = 2'd0;
    decim = 8'd2;
    do_arm();
    for (int k = 0; k < 24; k++) begin
`ifdef PROBE_DECIM_EN
      if (k % 3 == 2) push_sample(k, 200 + k, k == 23);
`else
      if (k < 8) push_sample(k, 200 + k, k == 7);
`endif
      strobe(k, 200 + k, 1'b0, 1);
    end
    wait_idle("dec_idle", 100);
    check("dec_wr_cnt", wr_cnt, 8);
    check("dec_done_cnt", done_cnt - d0, 1);
    check("dec_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
